// File: rtl/piano_mode_keymap_ctrl_pkg.sv
// Shared types and helpers for the piano mode controller and its key remap learner.
// Vector helpers take a fixed-width argument; callers zero-extend narrower key vectors.
package piano_pkg;

    localparam int unsigned MAX_KEYS = 32;

    typedef enum logic [1:0] {
        MODE_MENU = 2'd0,
        MODE_FREE = 2'd1,
        MODE_AUTO = 2'd2,
        MODE_LERN = 2'd3
    } mode_e;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_CLEAR   = 2'd1,
        S_COLLECT = 2'd2,
        S_COMMIT  = 2'd3
    } setup_state_e;

    function automatic logic onehot_check(input logic [MAX_KEYS-1:0] vec);
        return $countones(vec) == 1;
    endfunction

    // Returns 0 for an all-zero vector; callers qualify with their own valid term.
    function automatic int unsigned lowest_set_index(input logic [MAX_KEYS-1:0] vec);
        int unsigned idx;
        idx = 0;
        for (int i = MAX_KEYS - 1; i >= 0; i--) begin
            if (vec[i]) idx = unsigned'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/piano_mode_keymap_ctrl_keymap_learner.sv
// Press-order remap learner: builds a shadow key-to-note map from single key rises and
// commits it to the active map in one cycle once every key has been assigned.
module keymap_learner
    import piano_pkg::*;
#(
    parameter int unsigned NUM_KEYS = 8,
    parameter int unsigned IDX_W    = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_KEYS-1:0]       key_rise,
    input  logic                      setting,
    input  logic                      mode_is_menu,
    output logic [NUM_KEYS*IDX_W-1:0] map_flat,
    output logic                      setup_busy,
    output logic                      setup_done
);

    localparam int unsigned CNT_W = $clog2(NUM_KEYS + 1);
    localparam int unsigned KEY_W = (NUM_KEYS > 1) ? $clog2(NUM_KEYS) : 1;
    localparam logic [IDX_W-1:0] UNASSIGNED = '1;

    setup_state_e     state_q, state_d;
    logic             armed_q, armed_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [IDX_W-1:0] shadow_q [NUM_KEYS];
    logic [IDX_W-1:0] shadow_d [NUM_KEYS];
    logic [IDX_W-1:0] active_q [NUM_KEYS];
    logic [IDX_W-1:0] active_d [NUM_KEYS];

    logic [MAX_KEYS-1:0] rise_ext;
    logic [KEY_W-1:0]    press_key;
    logic                press_ok;

    assign rise_ext  = MAX_KEYS'(key_rise);
    assign press_key = KEY_W'(lowest_set_index(rise_ext));
    assign press_ok  = onehot_check(rise_ext) && (shadow_q[press_key] == UNASSIGNED);

    always_comb begin
        state_d  = state_q;
        armed_d  = armed_q;
        cnt_d    = cnt_q;
        shadow_d = shadow_q;
        active_d = active_q;
        // A held setting must be released before it can start another setup.
        if (!setting) armed_d = 1'b1;
        unique case (state_q)
            S_IDLE: begin
                if (setting && armed_q && mode_is_menu) begin
                    state_d = S_CLEAR;
                    armed_d = 1'b0;
                end
            end
            S_CLEAR: begin
                for (int k = 0; k < int'(NUM_KEYS); k++) shadow_d[k] = UNASSIGNED;
                cnt_d   = '0;
                state_d = setting ? S_COLLECT : S_IDLE;
            end
            S_COLLECT: begin
                if (!setting) begin
                    state_d = S_IDLE;
                end else if (press_ok) begin
                    shadow_d[press_key] = IDX_W'(cnt_q);
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(NUM_KEYS - 1)) state_d = S_COMMIT;
                end
            end
            S_COMMIT: begin
                active_d = shadow_q;
                state_d  = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            armed_q <= 1'b1;
            cnt_q   <= '0;
            for (int k = 0; k < int'(NUM_KEYS); k++) begin
                shadow_q[k] <= UNASSIGNED;
                active_q[k] <= IDX_W'(k);
            end
        end else begin
            state_q  <= state_d;
            armed_q  <= armed_d;
            cnt_q    <= cnt_d;
            shadow_q <= shadow_d;
            active_q <= active_d;
        end
    end

    for (genvar g = 0; g < NUM_KEYS; g++) begin : g_flat
        assign map_flat[g*IDX_W +: IDX_W] = active_q[g];
    end

    assign setup_busy = (state_q == S_CLEAR) || (state_q == S_COLLECT);
    assign setup_done = (state_q == S_COMMIT);

endmodule

// File: rtl/piano_mode_keymap_ctrl.sv
// Piano mode controller: MENU/FREE/AUTO/LERN mode FSM, input edge detection and a
// registered note lookup through the runtime key remap table.
module piano_mode_keymap_ctrl
    import piano_pkg::*;
#(
    parameter int unsigned NUM_KEYS = 8,
    parameter int unsigned IDX_W    = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_KEYS-1:0]       key_in,
    input  logic [1:0]                mode_sel,
    input  logic                      mode_go,
    input  logic                      back,
    input  logic                      setting,
    output logic [1:0]                mode,
    output logic [2:0]                mode_en,
    output logic [NUM_KEYS*IDX_W-1:0] map_flat,
    output logic                      setup_busy,
    output logic                      setup_done,
    output logic [IDX_W-1:0]          note_idx,
    output logic                      note_valid
);

    localparam int unsigned KEY_W = (NUM_KEYS > 1) ? $clog2(NUM_KEYS) : 1;

    logic [NUM_KEYS-1:0] key_q;
    logic                go_q, back_q;
    logic [NUM_KEYS-1:0] key_rise;
    logic                go_rise, back_rise;

    mode_e               mode_q, mode_d;
    logic [IDX_W-1:0]    note_idx_q, note_idx_d;
    logic                note_valid_q, note_valid_d;

    logic [IDX_W-1:0]    map_arr [NUM_KEYS];
    logic [KEY_W-1:0]    low_key;

    assign key_rise  = key_in & ~key_q;
    assign go_rise   = mode_go & ~go_q;
    assign back_rise = back & ~back_q;

    keymap_learner #(
        .NUM_KEYS (NUM_KEYS),
        .IDX_W    (IDX_W)
    ) u_learner (
        .clk          (clk),
        .rst          (rst),
        .key_rise     (key_rise),
        .setting      (setting),
        .mode_is_menu (mode_q == MODE_MENU),
        .map_flat     (map_flat),
        .setup_busy   (setup_busy),
        .setup_done   (setup_done)
    );

    // back takes priority over mode_go; playing modes only return to MENU.
    always_comb begin
        mode_d = mode_q;
        if (mode_q == MODE_MENU) begin
            if (!back_rise && go_rise && (mode_sel != MODE_MENU) && !setup_busy) begin
                mode_d = mode_e'(mode_sel);
            end
        end else if (back_rise) begin
            mode_d = MODE_MENU;
        end
    end

    always_comb begin
        mode_en = 3'b000;
        unique case (mode_q)
            MODE_MENU: mode_en = 3'b000;
            MODE_FREE: mode_en = 3'b001;
            MODE_AUTO: mode_en = 3'b010;
            MODE_LERN: mode_en = 3'b100;
            default:   mode_en = 3'b000;
        endcase
    end

    for (genvar g = 0; g < NUM_KEYS; g++) begin : g_unpack
        assign map_arr[g] = map_flat[g*IDX_W +: IDX_W];
    end

    assign low_key = KEY_W'(lowest_set_index(MAX_KEYS'(key_in)));

    always_comb begin
        note_valid_d = ((mode_q == MODE_FREE) || (mode_q == MODE_LERN)) && (|key_in)
                       && !setup_busy;
        note_idx_d   = note_valid_d ? map_arr[low_key] : '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            key_q        <= '0;
            go_q         <= 1'b0;
            back_q       <= 1'b0;
            mode_q       <= MODE_MENU;
            note_idx_q   <= '0;
            note_valid_q <= 1'b0;
        end else begin
            key_q        <= key_in;
            go_q         <= mode_go;
            back_q       <= back;
            mode_q       <= mode_d;
            note_idx_q   <= note_idx_d;
            note_valid_q <= note_valid_d;
        end
    end

    assign mode       = mode_q;
    assign note_idx   = note_idx_q;
    assign note_valid = note_valid_q;

endmodule

// File: tb/tb_piano_mode_keymap_ctrl.sv
// Bench for piano_mode_keymap_ctrl: a press-order behavioural model checked every cycle,
// plus directed scenarios with hand-computed literal expectations.
module tb_piano_mode_keymap_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  key_in;
    logic [1:0]  mode_sel;
    logic        mode_go, back, setting;
    logic [1:0]  mode;
    logic [2:0]  mode_en;
    logic [31:0] map_flat;
    logic        setup_busy, setup_done;
    logic [3:0]  note_idx;
    logic        note_valid;

    int n_chk  = 0;
    int n_pass = 0;
    int done_cnt = 0;
    int done_base;

    piano_mode_keymap_ctrl #(.NUM_KEYS(8), .IDX_W(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .key_in     (key_in),
        .mode_sel   (mode_sel),
        .mode_go    (mode_go),
        .back       (back),
        .setting    (setting),
        .mode       (mode),
        .mode_en    (mode_en),
        .map_flat   (map_flat),
        .setup_busy (setup_busy),
        .setup_done (setup_done),
        .note_idx   (note_idx),
        .note_valid (note_valid)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    // Model: mode number, note map per key, setup phase and the ordered list of accepted keys.
    int       m_mode;
    int       m_map [8];
    int       m_phase;   // 0 idle, 1 clearing, 2 collecting, 3 committing
    int       order [$];
    bit       m_armed;
    bit [7:0] p_key;
    bit       p_go, p_back;
    int       m_nidx;
    bit       m_nval;

    function automatic int lowest(input bit [7:0] v);
        for (int i = 0; i < 8; i++) if (v[i]) return i;
        return 0;
    endfunction

    function automatic bit in_order(input int k);
        foreach (order[i]) if (order[i] == k) return 1'b1;
        return 1'b0;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_mode = 0; m_phase = 0; m_armed = 1; order.delete();
            for (int k = 0; k < 8; k++) m_map[k] = k;
            p_key = 0; p_go = 0; p_back = 0; m_nidx = 0; m_nval = 0;
        end else begin
            bit [7:0] rise;
            bit       go_r, back_r, busy;
            int       nmode, nphase;
            rise   = key_in & ~p_key;
            go_r   = mode_go & !p_go;
            back_r = back & !p_back;
            busy   = (m_phase == 1) || (m_phase == 2);
            m_nval = (m_mode == 1 || m_mode == 3) && (key_in != 0) && !busy;
            m_nidx = m_nval ? m_map[lowest(key_in)] : 0;
            nmode = m_mode;
            if (m_mode != 0 && back_r) nmode = 0;
            else if (m_mode == 0 && go_r && !back_r && mode_sel != 0 && !busy) nmode = mode_sel;
            nphase = m_phase;
            case (m_phase)
                0: if (setting && m_armed && m_mode == 0) begin nphase = 1; m_armed = 0; end
                1: begin order.delete(); nphase = setting ? 2 : 0; end
                2: begin
                    if (!setting) nphase = 0;
                    else if ($countones(rise) == 1 && !in_order(lowest(rise))) begin
                        order.push_back(lowest(rise));
                        if (order.size() == 8) nphase = 3;
                    end
                end
                default: begin
                    foreach (order[i]) m_map[order[i]] = i;
                    nphase = 0;
                end
            endcase
            if (!setting) m_armed = 1;
            m_mode = nmode; m_phase = nphase;
            p_key = key_in; p_go = mode_go; p_back = back;
        end
    end

    function automatic logic [31:0] model_flat();
        logic [31:0] f;
        for (int k = 0; k < 8; k++) f[k*4 +: 4] = 4'(m_map[k]);
        return f;
    endfunction

    function automatic logic [2:0] model_en();
        case (m_mode)
            1: return 3'b001;
            2: return 3'b010;
            3: return 3'b100;
            default: return 3'b000;
        endcase
    endfunction

    always @(negedge clk) begin
        chk("mode", 32'(mode), 32'(m_mode));
        chk("mode_en", 32'(mode_en), 32'(model_en()));
        chk("map_flat", map_flat, model_flat());
        chk("setup_busy", 32'(setup_busy), 32'((m_phase == 1) || (m_phase == 2)));
        chk("setup_done", 32'(setup_done), 32'(m_phase == 3));
        chk("note_valid", 32'(note_valid), 32'(m_nval));
        chk("note_idx", 32'(note_idx), 32'(m_nidx));
        if (setup_done) done_cnt++;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic press(input int k);
        key_in = 8'(1 << k);
        tick(1);
        key_in = '0;
        tick(1);
    endtask

    task automatic go(input logic [1:0] sel);
        mode_sel = sel; mode_go = 1'b1;
        tick(1);
        mode_go = 1'b0;
        tick(1);
    endtask

    task automatic go_back();
        back = 1'b1;
        tick(1);
        back = 1'b0;
        tick(1);
    endtask

    initial begin
        rst = 1'b1; key_in = '0; mode_sel = '0; mode_go = 0; back = 0; setting = 0;
        tick(2);
        chk("reset map", map_flat, 32'h76543210);
        chk("reset mode", 32'(mode), 32'd0);
        rst = 1'b0;
        tick(1);

        // Identity lookup in FREE
        go(2'd1);
        key_in = 8'h20;
        tick(1);
        chk("free key5 idx", 32'(note_idx), 32'd5);
        chk("free key5 valid", 32'(note_valid), 32'd1);
        key_in = '0;
        tick(1);
        go_back();

        // AUTO entry, mode_go ignored outside MENU, back returns
        go(2'd2);
        chk("auto mode", 32'(mode), 32'd2);
        chk("auto en", 32'(mode_en), 32'b010);
        go(2'd1);
        chk("auto stays", 32'(mode), 32'd2);
        go_back();
        chk("menu en", 32'(mode_en), 32'd0);

        // Reverse press order
        done_base = done_cnt;
        setting = 1'b1;
        tick(2);
        chk("busy collect", 32'(setup_busy), 32'd1);
        for (int k = 7; k >= 0; k--) press(k);
        chk("done once", 32'(done_cnt - done_base), 32'd1);
        chk("reverse map", map_flat, 32'h01234567);
        setting = 1'b0;
        tick(1);
        go(2'd1);
        key_in = 8'h01;
        tick(1);
        chk("remapped key0", 32'(note_idx), 32'd7);
        key_in = '0;
        tick(1);
        go_back();

        // Rejected presses: simultaneous rise, repeated key
        setting = 1'b1;
        tick(2);
        key_in = 8'h14;
        tick(1);
        key_in = '0;
        tick(1);
        press(2);
        press(2);
        press(7); press(6); press(5); press(4); press(3); press(1); press(0);
        chk("reject map", map_flat, 32'h12345067);
        tick(3);
        chk("held setting no rearm", 32'(setup_busy), 32'd0);

        // Abort partway through
        setting = 1'b0;
        tick(1);
        done_base = done_cnt;
        setting = 1'b1;
        tick(2);
        press(0); press(1); press(2);
        setting = 1'b0;
        tick(2);
        chk("abort busy", 32'(setup_busy), 32'd0);
        chk("abort map", map_flat, 32'h12345067);
        chk("abort no done", 32'(done_cnt - done_base), 32'd0);
        setting = 1'b1;
        tick(2);
        chk("rearmed busy", 32'(setup_busy), 32'd1);
        setting = 1'b0;
        tick(2);

        // Reset mid-collect after a LERN visit; mode_go blocked while busy
        go(2'd3);
        chk("lern en", 32'(mode_en), 32'b100);
        go_back();
        setting = 1'b1;
        tick(2);
        press(3); press(4);
        go(2'd1);
        chk("go blocked busy", 32'(mode), 32'd0);
        rst = 1'b1;
        #1;
        chk("rst map", map_flat, 32'h76543210);
        chk("rst mode", 32'(mode), 32'd0);
        chk("rst busy", 32'(setup_busy), 32'd0);
        tick(1);
        setting = 1'b0;
        rst = 1'b0;
        tick(3);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
